// File: rtl/conversor_bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one shift per clock) between the ALU and the 7-segment driver.
// Optional macro LEADING_ZERO_BLANK_EN adds the BLANK output marking leading-zero digits.
module conversor_bcd #(
    parameter int BITS        = 14,
    parameter int DIGITS      = 4,
    parameter int MAX_DECIMAL = 9999
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [BITS-1:0]       BIN,
    input  logic                  SIGNO_IN,
    input  logic                  ERROR_IN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  SIGNO_OUT,
`ifdef LEADING_ZERO_BLANK_EN
    output logic [DIGITS-1:0]     BLANK,
`endif
    output logic                  ERROR_OUT
);

    localparam int SR_W  = 4*DIGITS + BITS;
    localparam int CNT_W = $clog2(BITS + 1);
    localparam logic [BITS-1:0]     MAX_BIN = BITS'(MAX_DECIMAL);
    localparam logic [4*DIGITS-1:0] NINES   = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    state_t                state_q;
    logic [SR_W-1:0]       sr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  sign_q;
    logic                  err_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic                  signo_q;
    logic                  error_q;
    logic                  done_q;

    logic [SR_W-1:0]       sr_d;
    logic [4*DIGITS-1:0]   bcd_d;
    logic                  over_s;

    // Digits are corrected from the pre-shift value, all in parallel, then the whole register moves left.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] fixed;
        fixed = sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr[BITS+4*d +: 4] >= 4'd5) begin
                fixed[BITS+4*d +: 4] = sr[BITS+4*d +: 4] + 4'd3;
            end else begin
                fixed[BITS+4*d +: 4] = sr[BITS+4*d +: 4];
            end
        end
        return {fixed[SR_W-2:0], 1'b0};
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q;

    // A digit is blanked only if it and every more significant digit are zero; units always shown.
    function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [4*DIGITS-1:0] b);
        logic [DIGITS-1:0] mask;
        logic              lead;
        mask = '0;
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lead    = lead & (b[4*k +: 4] == 4'd0);
            mask[k] = lead;
        end
        return mask;
    endfunction

    assign BLANK = blank_q;
`endif

    assign sr_d   = dabble_step(sr_q);
    assign bcd_d  = err_q ? NINES : sr_d[SR_W-1 -: 4*DIGITS];
    assign over_s = (BIN > MAX_BIN);

    // Conversion FSM; outputs load on the last shift so they are valid during the FIN (DONE) cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            bcd_q   <= '0;
            signo_q <= 1'b0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        sr_q    <= {{(4*DIGITS){1'b0}}, (over_s ? MAX_BIN : BIN)};
                        cnt_q   <= CNT_W'(BITS);
                        sign_q  <= SIGNO_IN;
                        err_q   <= ERROR_IN | over_s;
                        state_q <= ST_SHIFT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_q   <= bcd_d;
                        signo_q <= sign_q;
                        error_q <= err_q;
                        done_q  <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
                        blank_q <= err_q ? {DIGITS{1'b0}} : lead_zero_mask(bcd_d);
`endif
                        state_q <= ST_FIN;
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = done_q;
    assign BCD       = bcd_q;
    assign SIGNO_OUT = signo_q;
    assign ERROR_OUT = error_q;

endmodule

// File: tb/tb_conversor_bcd.sv
// Self-checking bench for conversor_bcd: directed scenarios plus randomized conversions against a decimal model.
module tb_conversor_bcd;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [13:0] BIN;
    logic        SIGNO_IN;
    logic        ERROR_IN;
    logic        BUSY;
    logic        DONE;
    logic [15:0] BCD;
    logic        SIGNO_OUT;
    logic        ERROR_OUT;
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0]  BLANK;
`endif

    int checks   = 0;
    int failures = 0;

    int          obs_done_cyc;
    int          obs_done_cnt;
    int          obs_busy;
    bit          obs_held_bad;
    logic [15:0] obs_bcd;
    logic        obs_s;
    logic        obs_e;
    logic [3:0]  obs_blank;

    conversor_bcd dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .BIN       (BIN),
        .SIGNO_IN  (SIGNO_IN),
        .ERROR_IN  (ERROR_IN),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .BCD       (BCD),
        .SIGNO_OUT (SIGNO_OUT),
`ifdef LEADING_ZERO_BLANK_EN
        .BLANK     (BLANK),
`endif
        .ERROR_OUT (ERROR_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Decimal reference: clamp/err rule then digit extraction by division.
    function automatic logic [15:0] model_bcd(input int v, input bit e);
        if (e || v > 9999) return 16'h9999;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] model_blank(input int v, input bit e);
        logic [3:0] m;
        m = 4'b0000;
        if (e || v > 9999) return m;
        m[1] = (v < 10);
        m[2] = (v < 100);
        m[3] = (v < 1000);
        return m;
    endfunction

    // Called at a negedge; START sampled at the next posedge (edge 0), observes cycles 1..win.
    task automatic do_conv(input int v, input bit s, input bit e, input int win,
                           input int restart_cyc, input int restart_v);
        logic [15:0] bcd0;
        bcd0         = BCD;
        obs_done_cyc = -1;
        obs_done_cnt = 0;
        obs_busy     = 0;
        obs_held_bad = 1'b0;
        BIN      = 14'(v);
        SIGNO_IN = s;
        ERROR_IN = e;
        START    = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        for (int c = 1; c <= win; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                BIN      = 14'($urandom);
                SIGNO_IN = 1'($urandom);
                ERROR_IN = 1'($urandom);
            end
            if (BUSY) obs_busy++;
            if (DONE) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) begin
                    obs_done_cyc = c;
                    obs_bcd = BCD;
                    obs_s   = SIGNO_OUT;
                    obs_e   = ERROR_OUT;
`ifdef LEADING_ZERO_BLANK_EN
                    obs_blank = BLANK;
`else
                    obs_blank = 4'b0000;
`endif
                end
            end else if (obs_done_cyc < 0 && BCD !== bcd0) begin
                obs_held_bad = 1'b1;
            end
            if (c == restart_cyc) begin
                BIN   = 14'(restart_v);
                START = 1'b1;
            end else begin
                START = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0; START = 1'b0; BIN = '0; SIGNO_IN = 1'b0; ERROR_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({BUSY, DONE, BCD, SIGNO_OUT, ERROR_OUT} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b bcd=%h s=%b e=%b exp all zero",
                     BUSY, DONE, BCD, SIGNO_OUT, ERROR_OUT);
        end
    endtask

    task automatic test_basic;
        do_conv(1234, 1'b0, 1'b0, 20, -1, 0);
        checks++;
        if (obs_done_cyc !== 15) begin
            failures++; $display("FAIL basic_latency got=%0d exp=15", obs_done_cyc);
        end
        checks++;
        if (obs_busy !== 15) begin
            failures++; $display("FAIL basic_busy_cycles got=%0d exp=15", obs_busy);
        end
        checks++;
        if (obs_done_cnt !== 1) begin
            failures++; $display("FAIL basic_done_count got=%0d exp=1", obs_done_cnt);
        end
        checks++;
        if (obs_bcd !== 16'h1234 || obs_e !== 1'b0 || obs_held_bad) begin
            failures++; $display("FAIL basic_value got=%h e=%b held_bad=%b exp=1234 e=0 held_bad=0",
                                 obs_bcd, obs_e, obs_held_bad);
        end
    endtask

    task automatic test_limits;
        int          vals [3] = '{9999, 10000, 7};
        bit          errs [3] = '{1'b0, 1'b0, 1'b1};
        bit          exp_e;
        for (int i = 0; i < 3; i++) begin
            do_conv(vals[i], 1'b0, errs[i], 20, -1, 0);
            exp_e = errs[i] | (vals[i] > 9999);
            checks++;
            if (obs_bcd !== 16'h9999 || obs_e !== exp_e || obs_done_cyc !== 15) begin
                failures++;
                $display("FAIL limits_%0d got bcd=%h e=%b cyc=%0d exp bcd=9999 e=%b cyc=15",
                         vals[i], obs_bcd, obs_e, obs_done_cyc, exp_e);
            end
        end
    endtask

    task automatic test_ignore_start;
        do_conv(5, 1'b1, 1'b0, 35, 3, 8000);
        checks++;
        if (obs_done_cnt !== 1 || obs_bcd !== 16'h0005 || obs_s !== 1'b1 || obs_e !== 1'b0) begin
            failures++;
            $display("FAIL ignore_busy got dones=%0d bcd=%h s=%b e=%b exp dones=1 bcd=0005 s=1 e=0",
                     obs_done_cnt, obs_bcd, obs_s, obs_e);
        end
        do_conv(321, 1'b0, 1'b0, 35, 15, 77);
        checks++;
        if (obs_done_cnt !== 1 || obs_bcd !== 16'h0321 || BCD !== 16'h0321) begin
            failures++;
            $display("FAIL ignore_fin got dones=%0d bcd=%h final=%h exp dones=1 bcd=0321 final=0321",
                     obs_done_cnt, obs_bcd, BCD);
        end
    endtask

    task automatic test_reset_abort;
        int dones;
        dones = 0;
        BIN = 14'd4321; SIGNO_IN = 1'b1; ERROR_IN = 1'b0; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (7) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        checks++;
        if ({BUSY, DONE, BCD, SIGNO_OUT, ERROR_OUT} !== 20'h0) begin
            failures++;
            $display("FAIL abort_outputs got busy=%b done=%b bcd=%h s=%b e=%b exp all zero",
                     BUSY, DONE, BCD, SIGNO_OUT, ERROR_OUT);
        end
        repeat (3) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        RST_N = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        checks++;
        if (dones !== 0 || BCD !== 16'h0000) begin
            failures++; $display("FAIL abort_no_done got dones=%0d bcd=%h exp dones=0 bcd=0000", dones, BCD);
        end
        do_conv(60, 1'b0, 1'b0, 20, -1, 0);
        checks++;
        if (obs_bcd !== 16'h0060 || obs_done_cyc !== 15) begin
            failures++; $display("FAIL abort_recover got bcd=%h cyc=%0d exp bcd=0060 cyc=15", obs_bcd, obs_done_cyc);
        end
    endtask

    task automatic test_back_to_back;
        int v; bit s; bit e;
        for (int i = 0; i < 30; i++) begin
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(10000, 16383) : $urandom_range(0, 9999);
            if (i == 0) v = 0;
            if (i == 1) v = 1000;
            if (i == 2) v = 42;
            s = 1'($urandom);
            e = ($urandom_range(0, 5) == 0);
            do_conv(v, s, e, 16, -1, 0);
            checks++;
            if (obs_done_cyc !== 15 || obs_bcd !== model_bcd(v, e) || obs_s !== s ||
                obs_e !== (e | (v > 9999)) || obs_held_bad) begin
                failures++;
                $display("FAIL b2b_%0d v=%0d got cyc=%0d bcd=%h s=%b e=%b held_bad=%b exp cyc=15 bcd=%h s=%b e=%b",
                         i, v, obs_done_cyc, obs_bcd, obs_s, obs_e, obs_held_bad,
                         model_bcd(v, e), s, e | (v > 9999));
            end
`ifdef LEADING_ZERO_BLANK_EN
            checks++;
            if (obs_blank !== model_blank(v, e)) begin
                failures++;
                $display("FAIL blank_%0d v=%0d got=%b exp=%b", i, v, obs_blank, model_blank(v, e));
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_limits();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
